// File: rtl/bcd_seq_ctrl_if.sv
// Command/status bundle for the BCD sequencing controller.
//
// Handshake: a command transfers at a rising clock edge where cmd_valid=1
// and cmd_ready=1. The master holds cmd_load/cmd_dir/cmd_arg stable while
// cmd_valid is high; cmd_ready is high only while the controller is IDLE.
//
// fsm_state is a debug view of the controller state: 0=IDLE, 1=RUN, 2=DONE.
interface bcd_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic       cmd_dir;
    logic [7:0] cmd_arg;
    logic       pause;
    logic       abort;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       err;
    logic [1:0] fsm_state;

    modport master (
        output cmd_valid, cmd_load, cmd_dir, cmd_arg, pause, abort,
        input  cmd_ready, count, busy, done, wrap, err, fsm_state
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_dir, cmd_arg, pause, abort,
        output cmd_ready, count, busy, done, wrap, err, fsm_state
    );
endinterface

// File: rtl/bcd_seq_ctrl.sv
// Two-digit BCD up/down sequencer. Accepts load or count commands in IDLE,
// steps the count once per unpaused cycle in RUN, and signals completion
// with a one-cycle DONE state. Wrap and reject conditions pulse for one cycle.
module bcd_seq_ctrl (
    input  logic          clock,
    input  logic          reset,
    bcd_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] count_q;
    logic [7:0] count_next;
    logic [7:0] remaining_q;
    logic [7:0] remaining_next;
    logic       dir_q;
    logic       dir_next;
    logic       wrap_q;
    logic       wrap_next;
    logic       err_q;
    logic       err_next;
    logic       arg_bad;

    // BCD increment with 99 rolling over to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    // BCD decrement with 00 rolling under to 99.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones == 4'd0) begin
            ones = 4'd9;
            tens = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
        end else begin
            ones = ones - 4'd1;
        end
        return {tens, ones};
    endfunction

    assign arg_bad = (bus.cmd_arg[7:4] > 4'd9) || (bus.cmd_arg[3:0] > 4'd9);

    // Next-state and datapath decisions; abort outranks pause and stepping.
    always_comb begin
        state_next     = state;
        count_next     = count_q;
        remaining_next = remaining_q;
        dir_next       = dir_q;
        wrap_next      = 1'b0;
        err_next       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (arg_bad) begin
                        err_next = 1'b1;
                    end else if (bus.cmd_load) begin
                        count_next = bus.cmd_arg;
                        state_next = DONE;
                    end else if (bus.cmd_arg == 8'h00) begin
                        state_next = DONE;
                    end else begin
                        state_next     = RUN;
                        remaining_next = bus.cmd_arg;
                        dir_next       = bus.cmd_dir;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (!bus.pause) begin
                    count_next     = dir_q ? bcd_dec(count_q) : bcd_inc(count_q);
                    wrap_next      = dir_q ? (count_q == 8'h00) : (count_q == 8'h99);
                    remaining_next = bcd_dec(remaining_q);
                    if (remaining_q == 8'h01) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and pulse registers; reset discards any in-flight command.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= 8'h00;
            remaining_q <= 8'h00;
            dir_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_next;
            remaining_q <= remaining_next;
            dir_q       <= dir_next;
            wrap_q      <= wrap_next;
            err_q       <= err_next;
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.count     = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.err       = err_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl: each scenario task drives vectors and
// compares outputs against hand-computed values one cycle at a time.
module tb_bcd_seq_ctrl;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    bcd_seq_ctrl_if bus ();

    bcd_seq_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock and reset defaults.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_arg   = 8'h00;
        bus.pause     = 1'b0;
        bus.abort     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Offer one command for one edge; the controller is assumed IDLE.
    task automatic send_cmd(input logic load, input logic dir, input logic [7:0] arg);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = load;
        bus.cmd_dir   = dir;
        bus.cmd_arg   = arg;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Load a value and let the DONE cycle pass.
    task automatic preload(input logic [7:0] v);
        send_cmd(1'b1, 1'b0, v);
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        total++; if (bus.count !== 8'h00) begin bad++; $display("FAIL reset_count got=%h want=00", bus.count); end
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.cmd_ready); end
        total++; if ({bus.busy, bus.done, bus.wrap, bus.err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {bus.busy, bus.done, bus.wrap, bus.err}); end
        total++; if (bus.fsm_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.fsm_state); end
    endtask

    task automatic test_load();
        do_reset();
        send_cmd(1'b1, 1'b0, 8'h47);
        total++; if (bus.count !== 8'h47) begin bad++; $display("FAIL load_count got=%h want=47", bus.count); end
        total++; if ({bus.done, bus.busy, bus.cmd_ready} !== 3'b110) begin bad++; $display("FAIL load_done_cycle got=%b want=110", {bus.done, bus.busy, bus.cmd_ready}); end
        tick();
        total++; if ({bus.done, bus.busy, bus.cmd_ready} !== 3'b001) begin bad++; $display("FAIL load_after got=%b want=001", {bus.done, bus.busy, bus.cmd_ready}); end
        total++; if (bus.count !== 8'h47) begin bad++; $display("FAIL load_hold got=%h want=47", bus.count); end
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp_cnt [7];
        exp_cnt = '{8'h96, 8'h97, 8'h98, 8'h99, 8'h00, 8'h01, 8'h02};
        preload(8'h95);
        send_cmd(1'b0, 1'b0, 8'h07);
        bus.cmd_dir = 1'b1;  // must not affect the latched direction
        for (int i = 0; i < 7; i++) begin
            tick();
            total++; if (bus.count !== exp_cnt[i]) begin bad++; $display("FAIL up_count step=%0d got=%h want=%h", i + 1, bus.count, exp_cnt[i]); end
            total++; if (bus.wrap !== (i == 4)) begin bad++; $display("FAIL up_wrap step=%0d got=%b want=%b", i + 1, bus.wrap, (i == 4)); end
            total++; if (bus.done !== (i == 6)) begin bad++; $display("FAIL up_done step=%0d got=%b want=%b", i + 1, bus.done, (i == 6)); end
        end
        tick();
        total++; if ({bus.cmd_ready, bus.done, bus.count} !== {2'b10, 8'h02}) begin bad++; $display("FAIL up_idle got=%b/%b/%h want=1/0/02", bus.cmd_ready, bus.done, bus.count); end
        bus.cmd_dir = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [7:0] exp_cnt [5];
        exp_cnt = '{8'h02, 8'h01, 8'h00, 8'h99, 8'h98};
        preload(8'h03);
        send_cmd(1'b0, 1'b1, 8'h05);
        bus.cmd_dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus.count !== exp_cnt[i]) begin bad++; $display("FAIL dn_count step=%0d got=%h want=%h", i + 1, bus.count, exp_cnt[i]); end
            total++; if (bus.wrap !== (i == 3)) begin bad++; $display("FAIL dn_wrap step=%0d got=%b want=%b", i + 1, bus.wrap, (i == 3)); end
            total++; if (bus.done !== (i == 4)) begin bad++; $display("FAIL dn_done step=%0d got=%b want=%b", i + 1, bus.done, (i == 4)); end
        end
        tick();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL dn_idle got=%b want=1", bus.cmd_ready); end
    endtask

    task automatic test_pause();
        logic [7:0] exp_cnt [13];
        exp_cnt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04, 8'h04,
                    8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10};
        preload(8'h00);
        send_cmd(1'b0, 1'b0, 8'h10);
        for (int k = 1; k <= 13; k++) begin
            bus.pause = (k >= 5 && k <= 7);
            tick();
            total++; if (bus.count !== exp_cnt[k - 1]) begin bad++; $display("FAIL pause_count edge=%0d got=%h want=%h", k, bus.count, exp_cnt[k - 1]); end
            total++; if (bus.done !== (k == 13)) begin bad++; $display("FAIL pause_done edge=%0d got=%b want=%b", k, bus.done, (k == 13)); end
            total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL pause_wrap edge=%0d got=%b want=0", k, bus.wrap); end
        end
        bus.pause = 1'b0;
        tick();
    endtask

    task automatic test_reject();
        preload(8'h25);
        send_cmd(1'b0, 1'b0, 8'h3A);
        total++; if ({bus.err, bus.cmd_ready, bus.busy} !== 3'b110) begin bad++; $display("FAIL rej_cnt_flags got=%b want=110", {bus.err, bus.cmd_ready, bus.busy}); end
        total++; if (bus.count !== 8'h25) begin bad++; $display("FAIL rej_cnt_count got=%h want=25", bus.count); end
        tick();
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rej_err_pulse got=%b want=0", bus.err); end
        send_cmd(1'b1, 1'b0, 8'hF0);
        total++; if ({bus.err, bus.cmd_ready, bus.busy} !== 3'b110) begin bad++; $display("FAIL rej_load_flags got=%b want=110", {bus.err, bus.cmd_ready, bus.busy}); end
        total++; if (bus.count !== 8'h25) begin bad++; $display("FAIL rej_load_count got=%h want=25", bus.count); end
        tick();
    endtask

    task automatic test_zero_count();
        preload(8'h58);
        send_cmd(1'b0, 1'b0, 8'h00);
        total++; if ({bus.done, bus.count} !== {1'b1, 8'h58}) begin bad++; $display("FAIL zero_cmd got=%b/%h want=1/58", bus.done, bus.count); end
        bus.abort = 1'b1;  // ignored in DONE
        tick();
        bus.abort = 1'b0;
        total++; if ({bus.done, bus.cmd_ready, bus.count} !== {2'b01, 8'h58}) begin bad++; $display("FAIL zero_after got=%b/%b/%h want=0/1/58", bus.done, bus.cmd_ready, bus.count); end
    endtask

    task automatic test_abort();
        preload(8'h00);
        send_cmd(1'b0, 1'b0, 8'h20);
        for (int i = 0; i < 4; i++) tick();
        total++; if (bus.count !== 8'h04) begin bad++; $display("FAIL abort_pre got=%h want=04", bus.count); end
        bus.abort = 1'b1;
        bus.pause = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.pause = 1'b0;
        total++; if ({bus.count, bus.cmd_ready, bus.busy, bus.done} !== {8'h04, 3'b100}) begin bad++; $display("FAIL abort_state got=%h/%b%b%b want=04/100", bus.count, bus.cmd_ready, bus.busy, bus.done); end
        tick();
        total++; if ({bus.count, bus.done} !== {8'h04, 1'b0}) begin bad++; $display("FAIL abort_after got=%h/%b want=04/0", bus.count, bus.done); end
    endtask

    task automatic test_reset_mid();
        preload(8'h00);
        send_cmd(1'b0, 1'b0, 8'h20);
        for (int i = 0; i < 4; i++) tick();
        do_reset();
        total++; if ({bus.count, bus.done, bus.cmd_ready} !== {8'h00, 2'b01}) begin bad++; $display("FAIL rstmid_state got=%h/%b/%b want=00/0/1", bus.count, bus.done, bus.cmd_ready); end
        tick();
        total++; if ({bus.count, bus.done} !== {8'h00, 1'b0}) begin bad++; $display("FAIL rstmid_after got=%h/%b want=00/0", bus.count, bus.done); end
    endtask

    task automatic test_back_to_back();
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b1;
        bus.cmd_arg   = 8'h11;
        tick();
        total++; if ({bus.count, bus.done} !== {8'h11, 1'b1}) begin bad++; $display("FAIL b2b_first got=%h/%b want=11/1", bus.count, bus.done); end
        bus.cmd_arg = 8'h22;
        tick();
        total++; if ({bus.count, bus.done, bus.cmd_ready} !== {8'h11, 2'b01}) begin bad++; $display("FAIL b2b_gap got=%h/%b/%b want=11/0/1", bus.count, bus.done, bus.cmd_ready); end
        tick();
        bus.cmd_valid = 1'b0;
        total++; if ({bus.count, bus.done} !== {8'h22, 1'b1}) begin bad++; $display("FAIL b2b_second got=%h/%b want=22/1", bus.count, bus.done); end
        tick();
    endtask

    // Scenario sequence and final report.
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load();
        test_up_wrap();
        test_down_wrap();
        test_pause();
        test_reject();
        test_zero_count();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
